// File: rtl/mov_branch_seq_pkg.sv
// Shared op codes and control-FSM state type for the move/branch execution unit.
package movbr_pkg;

    localparam int unsigned OP_BCF = 0;
    localparam int unsigned OP_BBF = 1;
    localparam int unsigned OP_BUC = 2;
    localparam int unsigned OP_TOG = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_HALT
    } state_e;

endpackage

// File: rtl/mov_branch_seq_pc_offset_add.sv
// Wrapping program-counter adder: sign-extends (or truncates) a DATA_W offset to PC_W.
module pc_offset_add #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] offset,
    output logic [PC_W-1:0]   sum
);

    logic [PC_W-1:0] off_ext;

    generate
        if (DATA_W >= PC_W) begin : g_trunc
            always_comb off_ext = offset[PC_W-1:0];
        end else begin : g_sext
            always_comb off_ext = {{(PC_W-DATA_W){offset[DATA_W-1]}}, offset};
        end
    endgenerate

    always_comb sum = pc + off_ext;

endmodule

// File: rtl/mov_branch_seq.sv
// Move/branch execution unit: register moves, conditional branches, out-pin toggle,
// program counter and RUN/FLUSH/HALT control FSM.
module mov_branch_seq
    import movbr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int PC_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [2*ADDR_W-1:0] addrs,
    input  logic [DATA_W-1:0]   src_data,
    input  logic [DATA_W-1:0]   offset,
    input  logic                carry_flag,
    input  logic                borrow_flag,
    output logic [PC_W-1:0]     pc,
    output logic                mov_we,
    output logic [ADDR_W-1:0]   mov_waddr,
    output logic [DATA_W-1:0]   mov_wdata,
    output logic                taken,
    output logic                flush,
    output logic                halted,
    output logic                out_sel,
    output logic [DATA_W-1:0]   out_bus
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                out_sel_q, out_sel_d;
    logic                mov_we_q, mov_we_d;
    logic [ADDR_W-1:0]   mov_waddr_q, mov_waddr_d;
    logic [DATA_W-1:0]   mov_wdata_q, mov_wdata_d;
    logic                taken_q, taken_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;

    logic [ADDR_W-1:0]   res_addr, src_addr;
    logic [PC_W-1:0]     pc_inc, pc_br;
    logic                accept, is_branch, branch_cond;

    pc_offset_add #(.PC_W(PC_W), .DATA_W(DATA_W)) u_br_add (
        .pc     (pc_q),
        .offset (offset),
        .sum    (pc_br)
    );

    pc_offset_add #(.PC_W(PC_W), .DATA_W(DATA_W)) u_inc_add (
        .pc     (pc_q),
        .offset (DATA_W'(1)),
        .sum    (pc_inc)
    );

    always_comb begin
        res_addr    = addrs[2*ADDR_W-1:ADDR_W];
        src_addr    = addrs[ADDR_W-1:0];
        accept      = (state_q == ST_RUN) && instr_valid;
        is_branch   = 1'b0;
        branch_cond = 1'b0;

        pc_d        = pc_q;
        out_sel_d   = out_sel_q;
        mov_we_d    = 1'b0;
        mov_waddr_d = mov_waddr_q;
        mov_wdata_d = mov_wdata_q;
        taken_d     = 1'b0;
        // FLUSH lasts one cycle and discards whatever is presented meanwhile.
        state_d     = (state_q == ST_FLUSH) ? ST_RUN : state_q;

        if (accept) begin
            if (res_addr != src_addr) begin
                mov_we_d    = 1'b1;
                mov_waddr_d = res_addr;
                mov_wdata_d = src_data;
                pc_d        = pc_inc;
            end else begin
                case (src_addr)
                    ADDR_W'(OP_BCF): begin is_branch = 1'b1; branch_cond = carry_flag;  end
                    ADDR_W'(OP_BBF): begin is_branch = 1'b1; branch_cond = borrow_flag; end
                    ADDR_W'(OP_BUC): begin is_branch = 1'b1; branch_cond = 1'b1;        end
                    ADDR_W'(OP_TOG): begin out_sel_d = ~out_sel_q; pc_d = pc_inc;       end
                    default:         pc_d = pc_inc;
                endcase
                if (is_branch) begin
                    if (branch_cond) begin
                        pc_d    = pc_br;
                        taken_d = 1'b1;
                        state_d = (offset == '0) ? ST_HALT : ST_FLUSH;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
        end

        flush_d  = (state_d == ST_FLUSH);
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= '0;
            out_sel_q   <= 1'b0;
            mov_we_q    <= 1'b0;
            mov_waddr_q <= '0;
            mov_wdata_q <= '0;
            taken_q     <= 1'b0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_sel_q   <= out_sel_d;
            mov_we_q    <= mov_we_d;
            mov_waddr_q <= mov_waddr_d;
            mov_wdata_q <= mov_wdata_d;
            taken_q     <= taken_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        pc        = pc_q;
        out_sel   = out_sel_q;
        mov_we    = mov_we_q;
        mov_waddr = mov_waddr_q;
        mov_wdata = mov_wdata_q;
        taken     = taken_q;
        flush     = flush_q;
        halted    = halted_q;
        out_bus   = out_sel_q ? DATA_W'(pc_q) : offset;
    end

endmodule

// File: tb/tb_mov_branch_seq.sv
// Self-checking bench for mov_branch_seq: directed scenarios plus randomized traffic
// against an arithmetic reference model.
module tb_mov_branch_seq;

    logic       clk = 1'b0;
    logic       rst, instr_valid, carry_flag, borrow_flag;
    logic [3:0] addrs;
    logic [7:0] src_data, offset;
    logic [7:0] pc;
    logic       mov_we;
    logic [1:0] mov_waddr;
    logic [7:0] mov_wdata;
    logic       taken, flush, halted, out_sel;
    logic [7:0] out_bus;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state; m_mode: 0 running, 1 flushing, 2 halted
    int m_pc, m_sel, m_we, m_waddr, m_wdata, m_taken, m_mode;

    always #5 clk = ~clk;

    mov_branch_seq #(.DATA_W(8), .ADDR_W(2), .PC_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .addrs       (addrs),
        .src_data    (src_data),
        .offset      (offset),
        .carry_flag  (carry_flag),
        .borrow_flag (borrow_flag),
        .pc          (pc),
        .mov_we      (mov_we),
        .mov_waddr   (mov_waddr),
        .mov_wdata   (mov_wdata),
        .taken       (taken),
        .flush       (flush),
        .halted      (halted),
        .out_sel     (out_sel),
        .out_bus     (out_bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] o,
                         input logic c, input logic b);
        rst = r; instr_valid = v; addrs = a; src_data = d; offset = o;
        carry_flag = c; borrow_flag = b;
    endtask

    task automatic model_edge();
        int res, src, soff;
        bit take;
        if (rst) begin
            m_pc = 0; m_sel = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_taken = 0; m_mode = 0;
            return;
        end
        m_we = 0;
        m_taken = 0;
        if (m_mode == 1) begin
            m_mode = 0;
        end else if (m_mode == 0 && instr_valid) begin
            res = int'(addrs) / 4;
            src = int'(addrs) % 4;
            if (res != src) begin
                m_we = 1; m_waddr = res; m_wdata = int'(src_data);
                m_pc = (m_pc + 1) % 256;
            end else if (src == 3) begin
                m_sel = 1 - m_sel;
                m_pc = (m_pc + 1) % 256;
            end else begin
                take = (src == 0) ? carry_flag : (src == 1) ? borrow_flag : 1'b1;
                if (take) begin
                    soff = (int'(offset) >= 128) ? int'(offset) - 256 : int'(offset);
                    m_pc = (m_pc + soff + 256) % 256;
                    m_taken = 1;
                    m_mode = (offset == 8'd0) ? 2 : 1;
                end else begin
                    m_pc = (m_pc + 1) % 256;
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("pc", pc, m_pc);
        check_val("mov_we", mov_we, m_we);
        check_val("mov_waddr", mov_waddr, m_waddr);
        check_val("mov_wdata", mov_wdata, m_wdata);
        check_val("taken", taken, m_taken);
        check_val("flush", flush, (m_mode == 1) ? 1 : 0);
        check_val("halted", halted, (m_mode == 2) ? 1 : 0);
        check_val("out_sel", out_sel, m_sel);
        check_val("out_bus", out_bus, (m_sel != 0) ? m_pc : int'(offset));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic goto_pc(input int n);
        drive(1, 0, 4'b0000, 8'h00, 8'h00, 0, 0);
        step();
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 4'b0100, 8'(i), 8'h00, 0, 0);
            step();
        end
    endtask

    initial begin
        drive(1, 0, 4'b0000, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        step();
        check_val("rst_pc", pc, 0);
        check_val("rst_flush", flush, 0);

        // first move after reset
        drive(0, 1, 4'b1101, 8'h5A, 8'h00, 0, 0);
        step();
        check_val("mv_we", mov_we, 1);
        check_val("mv_waddr", mov_waddr, 3);
        check_val("mv_wdata", mov_wdata, 8'h5A);
        check_val("mv_pc", pc, 1);

        // BCF taken backwards, then wrong-path instr during FLUSH
        goto_pc(10);
        drive(0, 1, 4'b0000, 8'h11, 8'hFD, 1, 0);
        step();
        check_val("bcf_pc", pc, 7);
        check_val("bcf_taken", taken, 1);
        check_val("bcf_flush", flush, 1);
        drive(0, 1, 4'b0110, 8'h22, 8'h00, 0, 0);
        step();
        check_val("fl_pc", pc, 7);
        check_val("fl_we", mov_we, 0);
        check_val("fl_flush", flush, 0);
        drive(0, 1, 4'b0110, 8'h22, 8'h00, 0, 0);
        step();
        check_val("run_pc", pc, 8);

        // BBF not taken / taken
        goto_pc(10);
        drive(0, 1, 4'b0101, 8'h00, 8'h04, 0, 0);
        step();
        check_val("bbf_nt_pc", pc, 11);
        check_val("bbf_nt_taken", taken, 0);
        check_val("bbf_nt_flush", flush, 0);
        goto_pc(10);
        drive(0, 1, 4'b0101, 8'h00, 8'h04, 0, 1);
        step();
        check_val("bbf_t_pc", pc, 14);
        drive(0, 0, 4'b0000, 8'h00, 8'h04, 0, 0);
        step();

        // TOG twice
        drive(0, 0, 4'b0000, 8'h00, 8'h3C, 0, 0);
        step();
        check_val("tog0_bus", out_bus, 8'h3C);
        drive(0, 1, 4'b1111, 8'h00, 8'h3C, 0, 0);
        step();
        check_val("tog1_sel", out_sel, 1);
        check_val("tog1_bus", out_bus, 15);
        drive(0, 1, 4'b1111, 8'h00, 8'h3C, 0, 0);
        step();
        check_val("tog2_sel", out_sel, 0);
        check_val("tog2_bus", out_bus, 8'h3C);
        check_val("tog2_pc", pc, 16);

        // BUC with zero offset halts
        drive(0, 1, 4'b1010, 8'h00, 8'h00, 0, 0);
        step();
        check_val("halt_flag", halted, 1);
        check_val("halt_pc", pc, 16);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        check_val("halt_hold_pc", pc, 16);
        drive(1, 1, 4'b1101, 8'h00, 8'h00, 0, 0);
        step();
        check_val("halt_rst_pc", pc, 0);
        check_val("halt_rst_flag", halted, 0);

        // pc wrap both ways, then reset mid-FLUSH
        goto_pc(255);
        check_val("pre_wrap_pc", pc, 8'hFF);
        drive(0, 1, 4'b0100, 8'h01, 8'h00, 0, 0);
        step();
        check_val("wrap_up_pc", pc, 0);
        drive(0, 1, 4'b1010, 8'h00, 8'hFF, 0, 0);
        step();
        check_val("wrap_dn_pc", pc, 8'hFF);
        check_val("wrap_dn_flush", flush, 1);
        drive(1, 1, 4'b0100, 8'h00, 8'h00, 0, 0);
        step();
        check_val("rstfl_pc", pc, 0);
        check_val("rstfl_flush", flush, 0);
        check_val("rstfl_taken", taken, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  4'($urandom), 8'($urandom),
                  ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom), 1'($urandom));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
